q_argmax_select: RTL and testbench

Q_ARGMAX_SELECT -- requirements
Module: q_argmax_select

---
 rtl/q_argmax_select_pkg.sv | 22 ++
 rtl/q_argmax_select_fp32_key_cmp.sv | 18 +
 rtl/q_argmax_select.sv | 103 ++++++++++
 tb/tb_q_argmax_select.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/q_argmax_select_pkg.sv
// Shared FP32 helpers for the Q argmax selector: ordered-key mapping, NaN detect, constants.
package q_argmax_select_pkg;

  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;
  localparam logic [31:0] FP32_NINF = 32'hFF80_0000;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } sel_state_t;

  // Maps float bits onto an unsigned key whose ordering matches numeric ordering.
  function automatic logic [31:0] fp32_key(input logic [31:0] bits);
    return bits[31] ? ~bits : (bits ^ 32'h8000_0000);
  endfunction

  function automatic logic fp32_is_nan(input logic [31:0] bits);
    return (bits[30:23] == 8'hFF) && (bits[22:0] != 23'd0);
  endfunction

endpackage

// File: rtl/q_argmax_select_fp32_key_cmp.sv
// Combinational ordered-key greater-than between a candidate Q beat and the running best.
module fp32_key_cmp
  import q_argmax_select_pkg::*;
(
  input  logic [31:0] cand,
  input  logic [31:0] best,
  output logic        cand_gt,
  output logic        cand_nan,
  output logic        best_nan
);

  always_comb begin
    cand_gt  = fp32_key(cand) > fp32_key(best);
    cand_nan = fp32_is_nan(cand);
    best_nan = fp32_is_nan(best);
  end

endmodule

// File: rtl/q_argmax_select.sv
// Streams NUM_ARMS Q values per round and returns the index and bits of the largest one.
//   state      | meaning
//   ST_COLLECT | accepting Q beats, tracking the running best
//   ST_HOLD    | result presented, waiting for downstream handshake
module q_argmax_select
  import q_argmax_select_pkg::*;
#(
  parameter int NUM_ARMS = 8,
  parameter int IDX_W    = $clog2(NUM_ARMS)
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic [31:0]      s_axis_q_tdata,
  input  logic             s_axis_q_tvalid,
  output logic             s_axis_q_tready,
  input  logic             s_axis_q_tlast,
  output logic [IDX_W-1:0] m_axis_sel_tdata,
  output logic [31:0]      m_axis_sel_qmax,
  output logic             m_axis_sel_err,
  output logic             m_axis_sel_tvalid,
  input  logic             m_axis_sel_tready
);

  localparam int             LAST_BEAT = NUM_ARMS - 1;
  localparam logic [IDX_W:0] LAST_CNT  = LAST_BEAT[IDX_W:0];

  sel_state_t     state;
  sel_state_t     state_nxt;
  logic [IDX_W:0] cnt;

  logic accept;
  logic at_last;
  logic closing;
  logic round_err;
  logic sel_hs;
  logic take;
  logic cand_gt;
  logic cand_nan;
  logic best_nan;

  // The running best lives directly in the result registers; tvalid qualifies them.
  fp32_key_cmp u_cmp (
    .cand     (s_axis_q_tdata),
    .best     (m_axis_sel_qmax),
    .cand_gt  (cand_gt),
    .cand_nan (cand_nan),
    .best_nan (best_nan)
  );

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: if (accept && closing) state_nxt = ST_HOLD;
      ST_HOLD:    if (m_axis_sel_tready) state_nxt = ST_COLLECT;
      default:    state_nxt = ST_COLLECT;
    endcase
  end

  always_comb begin
    s_axis_q_tready   = (state == ST_COLLECT);
    m_axis_sel_tvalid = (state == ST_HOLD);
  end

  always_comb begin
    accept    = s_axis_q_tvalid && s_axis_q_tready;
    sel_hs    = m_axis_sel_tvalid && m_axis_sel_tready;
    at_last   = (cnt == LAST_CNT);
    closing   = s_axis_q_tlast || at_last;
    // Short round (tlast before the final arm) or long round (final arm without tlast).
    round_err = (s_axis_q_tlast && !at_last) || (at_last && !s_axis_q_tlast);
    // A NaN best (only possible from the first beat) yields to any non-NaN beat.
    take      = (cnt == '0) || (!cand_nan && (best_nan || cand_gt));
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt              <= '0;
      m_axis_sel_tdata <= '0;
      m_axis_sel_qmax  <= '0;
      m_axis_sel_err   <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (take) begin
        m_axis_sel_tdata <= cnt[IDX_W-1:0];
        m_axis_sel_qmax  <= s_axis_q_tdata;
      end
      if (closing) begin
        m_axis_sel_err <= round_err;
      end
    end else if (sel_hs) begin
      cnt <= '0;
    end
  end

endmodule

// File: tb/tb_q_argmax_select.sv
// Randomized scoreboard bench for q_argmax_select with NUM_ARMS=4 plus directed corner rounds.
module tb_q_argmax_select;
  import q_argmax_select_pkg::*;

  localparam int NA = 4;
  localparam int IW = 2;

  logic          aclk = 1'b0;
  logic          areset;
  logic [31:0]   s_tdata;
  logic          s_tvalid;
  logic          s_tready;
  logic          s_tlast;
  logic [IW-1:0] m_tdata;
  logic [31:0]   m_qmax;
  logic          m_err;
  logic          m_tvalid;
  logic          m_tready;

  typedef struct {
    logic [IW-1:0] idx;
    logic [31:0]   q;
    logic          err;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          hold_ready = 1'b0;
  logic [31:0] rb[NA];

  bit            held = 1'b0;
  logic [IW-1:0] cap_idx;
  logic [31:0]   cap_q;
  logic          cap_err;
  exp_t          e_mon;

  q_argmax_select #(.NUM_ARMS(NA), .IDX_W(IW)) dut (
    .aclk              (aclk),
    .areset            (areset),
    .s_axis_q_tdata    (s_tdata),
    .s_axis_q_tvalid   (s_tvalid),
    .s_axis_q_tready   (s_tready),
    .s_axis_q_tlast    (s_tlast),
    .m_axis_sel_tdata  (m_tdata),
    .m_axis_sel_qmax   (m_qmax),
    .m_axis_sel_err    (m_err),
    .m_axis_sel_tvalid (m_tvalid),
    .m_axis_sel_tready (m_tready)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Reference ordering straight from float semantics: sign first, then magnitude.
  function automatic bit model_nan(input logic [31:0] v);
    return (v[30:23] == 8'd255) && (v[22:0] != 23'd0);
  endfunction

  function automatic bit model_gt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return b[31];
    if (!a[31]) return a[30:0] > b[30:0];
    return a[30:0] < b[30:0];
  endfunction

  function automatic exp_t model_round(input int len, input bit tl);
    exp_t e;
    int   best = -1;
    for (int i = 0; i < len; i++) begin
      if (!model_nan(rb[i]) && (best < 0 || model_gt(rb[i], rb[best]))) best = i;
    end
    if (best < 0) best = 0;
    e.idx = best[IW-1:0];
    e.q   = rb[best];
    e.err = tl ? (len < NA) : 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] rand_val();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 9))
      0: return FP32_QNAN;
      1: return FP32_PINF;
      2: return FP32_NINF;
      3: return 32'h0000_0000;
      4: return 32'h8000_0000;
      5: return 32'h3F80_0000;
      6: return {r[31], 8'hFF, r[22:1], 1'b1};
      default: return r;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat's handshake edge.
  task automatic send_beat(input logic [31:0] d, input bit last);
    int guard;
    guard    = 0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    @(negedge aclk);
    while (!s_tready && guard < 200) begin
      @(negedge aclk);
      guard++;
    end
    if (!s_tready) timeout_fail("beat_accept");
    @(posedge aclk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic send_round(input int len, input bit tl);
    sb_q.push_back(model_round(len, tl));
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge aclk);
        #1;
      end
      send_beat(rb[i], tl && (i == len - 1));
    end
    check("tvalid_latency", 32'(m_tvalid), 32'd1);
  endtask

  task automatic set_rb(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input logic [31:0] d);
    rb[0] = a;
    rb[1] = b;
    rb[2] = c;
    rb[3] = d;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || m_tvalid) && guard < 500) begin
      @(posedge aclk);
      #1;
      guard++;
    end
    if (sb_q.size() != 0 || m_tvalid) timeout_fail("drain");
  endtask

  always begin
    @(posedge aclk);
    #1;
    m_tready = hold_ready ? 1'b0 : ($urandom_range(0, 2) != 0);
  end

  always @(negedge aclk) begin
    if (areset) begin
      held = 1'b0;
    end else if (m_tvalid) begin
      if (held) begin
        check("hold_idx_stable", 32'(m_tdata), 32'(cap_idx));
        check("hold_qmax_stable", m_qmax, cap_q);
        check("hold_err_stable", 32'(m_err), 32'(cap_err));
      end else begin
        cap_idx = m_tdata;
        cap_q   = m_qmax;
        cap_err = m_err;
        held    = 1'b1;
      end
      if (m_tready) begin
        if (sb_q.size() == 0) begin
          timeout_fail("unexpected_result");
        end else begin
          e_mon = sb_q.pop_front();
          check("sel_index", 32'(m_tdata), 32'(e_mon.idx));
          check("sel_qmax", m_qmax, e_mon.q);
          check("sel_err", 32'(m_err), 32'(e_mon.err));
        end
        held = 1'b0;
      end
    end else begin
      held = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int len;
    bit tl;
    areset   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_s_tready", 32'(s_tready), 32'd1);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_idx", 32'(m_tdata), 32'd0);
    check("rst_qmax", m_qmax, 32'd0);
    check("rst_err", 32'(m_err), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;

    set_rb(32'h3F80_0000, 32'h4000_0000, 32'h3F00_0000, 32'h3FC0_0000);
    send_round(4, 1'b1);
    set_rb(32'hBF80_0000, 32'hBF00_0000, 32'hC000_0000, 32'hBF00_0000);
    send_round(4, 1'b1);
    set_rb(FP32_QNAN, FP32_NINF, FP32_QNAN, 32'h4040_0000);
    send_round(4, 1'b1);
    set_rb(FP32_QNAN, 32'hFFC0_0000, 32'h7F80_0001, FP32_QNAN);
    send_round(4, 1'b1);
    set_rb(32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0);
    send_round(2, 1'b1);
    set_rb(32'h3F80_0000, 32'h3F00_0000, 32'h4080_0000, 32'h4000_0000);
    send_round(4, 1'b0);
    set_rb(32'h8000_0000, 32'h0000_0000, FP32_NINF, 32'h8000_0000);
    send_round(4, 1'b1);
    set_rb(FP32_PINF, 32'h3F80_0000, FP32_PINF, FP32_NINF);
    send_round(3, 1'b1);

    // Downstream stall while upstream keeps offering the next beat.
    wait_drain();
    hold_ready = 1'b1;
    @(posedge aclk);
    #1;
    set_rb(32'h4000_0000, 32'h4040_0000, 32'h3F80_0000, 32'h3F00_0000);
    send_round(4, 1'b1);
    set_rb(32'h40A0_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
    s_tdata  = rb[0];
    s_tlast  = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("stall_s_tready", 32'(s_tready), 32'd0);
      check("stall_tvalid", 32'(m_tvalid), 32'd1);
    end
    hold_ready = 1'b0;
    send_round(4, 1'b1);

    // Asynchronous reset in the middle of a round.
    wait_drain();
    set_rb(32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h0);
    send_beat(rb[0], 1'b0);
    send_beat(rb[1], 1'b0);
    @(negedge aclk);
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_s_tready", 32'(s_tready), 32'd1);
    check("mid_rst_tvalid", 32'(m_tvalid), 32'd0);
    check("mid_rst_idx", 32'(m_tdata), 32'd0);
    check("mid_rst_qmax", m_qmax, 32'd0);
    check("mid_rst_err", 32'(m_err), 32'd0);
    @(negedge aclk);
    areset = 1'b0;
    @(posedge aclk);
    #1;
    set_rb(32'h3F00_0000, 32'h4040_0000, 32'h4080_0000, 32'hBF80_0000);
    send_round(4, 1'b1);

    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < NA; i++) begin
        rb[i] = (i > 0 && $urandom_range(0, 4) == 0) ? rb[i-1] : rand_val();
      end
      len = $urandom_range(1, NA);
      tl  = (len < NA) ? 1'b1 : ($urandom_range(0, 1) == 1);
      send_round(len, tl);
    end

    wait_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
